// File: rtl/uart_rx.sv
// 8N1 UART receiver. A two-flop synchroniser feeds a timer-driven FSM that
// validates the start bit and samples every bit at its midpoint.
module uart_rx #(
  parameter int unsigned BAUD_RATE    = 9_600,
  parameter int unsigned SYS_CLK_FREQ = 48_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned BIT_PERIOD  = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
  localparam int unsigned TIMER_W     = $clog2(BIT_PERIOD);
  localparam int unsigned IDX_W       = 3;

  localparam logic [TIMER_W-1:0] TIMER_FULL = TIMER_W'(BIT_PERIOD - 1);
  localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0]   LAST_BIT   = IDX_W'(7);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic [TIMER_W-1:0] r_timer;
  logic [IDX_W-1:0]   r_bit_index;
  logic [7:0]         r_shift;
  logic [7:0]         r_data_out;
  logic               r_data_valid;
  logic               r_frame_error;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [IDX_W-1:0]   w_bit_index_nxt;
  logic [7:0]         w_shift_nxt;
  logic [7:0]         w_data_out_nxt;
  logic               w_data_valid_nxt;
  logic               w_frame_error_nxt;
  logic               w_busy_nxt;
  logic               w_timer_done;

  assign w_timer_done = (r_timer == '0);

  // State register, synchroniser and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_timer       <= '0;
      r_bit_index   <= '0;
      r_shift       <= 8'h00;
      r_data_out    <= 8'h00;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sync1       <= rx;
      r_sync2       <= r_sync1;
      r_timer       <= w_timer_nxt;
      r_bit_index   <= w_bit_index_nxt;
      r_shift       <= w_shift_nxt;
      r_data_out    <= w_data_out_nxt;
      r_data_valid  <= w_data_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  // Next-state, timer, bit index and shift register
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_bit_index_nxt = r_bit_index;
    w_shift_nxt     = r_shift;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = S_START;
          w_timer_nxt = TIMER_HALF;
        end
      end
      S_START: begin
        if (!w_timer_done) begin
          w_timer_nxt = r_timer - TIMER_W'(1);
        end else if (!r_sync2) begin
          w_state_nxt     = S_DATA;
          w_timer_nxt     = TIMER_FULL;
          w_bit_index_nxt = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (!w_timer_done) begin
          w_timer_nxt = r_timer - TIMER_W'(1);
        end else begin
          w_shift_nxt[r_bit_index] = r_sync2;
          w_timer_nxt              = TIMER_FULL;
          if (r_bit_index == LAST_BIT) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_index_nxt = r_bit_index + IDX_W'(1);
          end
        end
      end
      S_STOP: begin
        if (!w_timer_done) begin
          w_timer_nxt = r_timer - TIMER_W'(1);
        end else if (r_sync2) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // A low line here is a break or stuck line, never a new start bit
        if (r_sync2) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs: strobes default low, data_out holds until a good frame
  always_comb begin
    w_data_out_nxt    = r_data_out;
    w_data_valid_nxt  = 1'b0;
    w_frame_error_nxt = 1'b0;
    w_busy_nxt        = (w_state_nxt != S_IDLE);
    if (r_state == S_STOP && w_timer_done) begin
      if (r_sync2) begin
        w_data_out_nxt   = r_shift;
        w_data_valid_nxt = 1'b1;
      end else begin
        w_frame_error_nxt = 1'b1;
      end
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a table of frames plus hand-written corner sequences;
// expected strobes go through a scoreboard queue popped by an output monitor.
module tb_uart_rx;

  localparam int unsigned BAUD = 1_000_000;
  localparam int unsigned FCLK = 8_000_000;
  localparam int unsigned BP   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  uart_rx #(.BAUD_RATE(BAUD), .SYS_CLK_FREQ(FCLK)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int unsigned hold_low;
    logic        exp_err;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned n_valid = 0;
  int unsigned n_ferr = 0;
  logic        busy_seen = 1'b0;
  logic [7:0]  last_good = 8'h00;
  exp_t        sb[$];
  int unsigned valid_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_seen = 1'b1;
    if (data_valid && frame_error) check("strobe_exclusive", 32'd1, 32'd0);
    if (data_valid) begin
      n_valid++;
      valid_cyc.push_back(cyc);
    end
    if (frame_error) n_ferr++;
    if (data_valid || frame_error) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got valid=%0b ferr=%0b data=%0h expected none (cycle %0d)",
                 data_valid, frame_error, data_out, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_kind_ferr", 32'(frame_error), 32'(e.err));
        check("data_out", 32'(data_out), 32'(e.data));
      end
    end
  end

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BP) wait_clk();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic exp_err);
    exp_t e;
    e.err  = exp_err;
    e.data = exp_err ? last_good : d;
    if (!exp_err) last_good = d;
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3 * BP && sb.size() != 0; i++) wait_clk();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain_timeout: got %0d pending strobes expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int unsigned d01;
    vecs[0] = '{8'hA5, 1'b1, 0,  1'b0};
    vecs[1] = '{8'h01, 1'b1, 0,  1'b0};
    vecs[2] = '{8'h80, 1'b1, 0,  1'b0};
    vecs[3] = '{8'h3C, 1'b0, 40, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 0,  1'b0};
    vecs[5] = '{8'h7E, 1'b1, 0,  1'b0};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) wait_clk();
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2 * BP) wait_clk();

    // Table-driven frames, including a framing error held low as a break
    for (int v = 0; v < 6; v++) begin
      busy_seen = 1'b0;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].exp_err);
      if (vecs[v].hold_low > 0) begin
        rx = 1'b0;
        repeat (vecs[v].hold_low) wait_clk();
        check("busy_wait_idle", 32'(busy), 32'd1);
        rx = 1'b1;
      end
      repeat (2 * BP) wait_clk();
      drain("table");
      check("table_busy_seen", 32'(busy_seen), 32'd1);
      check("table_busy_idle", 32'(busy), 32'd0);
      check("table_data_out", 32'(data_out), 32'(last_good));
    end
    check("table_ferr_count", n_ferr, 32'd1);

    // Back-to-back frames with no idle gap
    valid_cyc.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (BP) wait_clk();
    drain("b2b");
    check("b2b_count", valid_cyc.size(), 32'd2);
    if (valid_cyc.size() == 2) begin
      d01 = valid_cyc[1] - valid_cyc[0];
      check("b2b_spacing_ok", 32'((d01 >= 79) && (d01 <= 81)), 32'd1);
    end

    // Short glitch: START check rejects it without any strobe
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (2) wait_clk();
    rx = 1'b1;
    repeat (12) wait_clk();
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_data_out", 32'(data_out), 32'hFF);

    // Reset in the middle of data bit 4 aborts the frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rx = 1'b1;
    repeat (BP / 2) wait_clk();
    reset = 1'b1;
    wait_clk();
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_data_valid", 32'(data_valid), 32'd0);
    check("midrst_frame_error", 32'(frame_error), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    last_good = 8'h00;
    repeat (3 * BP) wait_clk();
    check("midrst_no_strobe", 32'(data_out), 32'h00);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (BP) wait_clk();
    drain("midrst");
    check("midrst_after_frame", 32'(data_out), 32'hC3);

    // Loopback stream of every byte value, frames back to back
    n_valid = 0;
    n_ferr  = 0;
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, 1'b0);
    repeat (2 * BP) wait_clk();
    drain("loop");
    check("loop_valid_count", n_valid, 32'd256);
    check("loop_ferr_count", n_ferr, 32'd0);
    check("loop_last", 32'(data_out), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity.
- Synchronises the asynchronous rx line, validates the start bit, and samples each bit at mid-period.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Receive-side counterpart of the team's uart_tx; shares its baud and clock parameters so a tx/rx pair links directly.

Parameters:
- BAUD_RATE, 9_600, line bit rate in bits/s.
- SYS_CLK_FREQ, 48_000_000, clk frequency in Hz.
- Derived BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE (integer division). Requires BIT_PERIOD >= 4.
- Derived HALF_PERIOD = BIT_PERIOD / 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  8  last correctly framed byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE, data_out=8'h00, data_valid=0, frame_error=0, busy=0.
  - Shift register=0, bit_index=0, timer=0.
  - Both synchroniser flops=1 (line idle).
- Reset mid-frame aborts immediately; no strobe is issued for the partial frame.
- Input sync: rx passes through 2 flops to give rx_s. All decisions use rx_s only, so rx_s lags rx by 2 cycles.
- data_valid and frame_error default to 0 every cycle; they are never high together.
- Timer: width $clog2(BIT_PERIOD). A state acts on its sample in the cycle where timer==0; otherwise the timer decrements.
- States:
  - IDLE: busy=0. If rx_s==0, go to START with timer=HALF_PERIOD-1 and busy=1.
  - START: at timer==0, check rx_s (start-bit midpoint).
    - rx_s==0: go to DATA, timer=BIT_PERIOD-1, bit_index=0.
    - rx_s==1: glitch or false start. Return to IDLE; no strobe issued.
  - DATA: at timer==0, shift[bit_index]=rx_s (LSB first).
    - bit_index==7: go to STOP, timer=BIT_PERIOD-1.
    - Otherwise: bit_index+1, timer=BIT_PERIOD-1.
  - STOP: at timer==0, check rx_s.
    - rx_s==1: data_out=shift and data_valid=1 in the next cycle, then go to IDLE.
    - rx_s==0: frame_error=1, data_out unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: busy=1. Stay until rx_s==1, then go to IDLE. This prevents a break condition or stuck-low line from being re-read as a stream of start bits.
- Latency: data_valid rises (2 + HALF_PERIOD + 9*BIT_PERIOD + 1) cycles ±1 after the rx falling edge.
- Back-to-back frames: returning to IDLE at the stop-bit midpoint leaves half a bit period of margin. A start edge arriving right after the stop midpoint must be caught.
- No buffering: the consumer must take data_out within one frame time (10*BIT_PERIOD cycles), or it is overwritten.
- Start edge during reset deassert: sampled only after reset is low; a frame already in flight is resynchronised at the next falling edge.

Test Plan:
Bench setup: BAUD_RATE=1_000_000, SYS_CLK_FREQ=8_000_000, giving BIT_PERIOD=8 and HALF_PERIOD=4.
1. Drive an 8N1 frame of 0xA5 -> exactly one data_valid pulse with data_out=8'hA5; frame_error stays 0; busy high during the frame, then 0.
2. Send 0x00 then 0xFF with no idle gap between stop and start -> two data_valid pulses, values 8'h00 then 8'hFF, 80 cycles apart ±1.
3. Pulse rx low for 2 cycles -> busy rises then returns to 0 after the START check; no data_valid, no frame_error; data_out unchanged.
4. Send 0x3C with the stop bit forced low and rx held low for 40 more cycles -> one frame_error pulse; data_out retains its previous value; busy stays 1 while low. Then release rx and send 0x5A -> data_valid with 8'h5A.
5. Assert reset for 1 cycle mid-way through data bit 4 of a frame -> all outputs return to reset values next cycle; no strobe for the aborted frame. The next full frame 0xC3 is received correctly.
6. Loopback uart_tx -> uart_rx with the same parameters, sending 256 sequential bytes 0x00..0xFF -> 256 data_valid pulses, in order, bit-exact, zero frame_error.
